video_scan_ctrl: RTL and testbench
==================================

VIDEO_SCAN_CTRL -- requirements
Module: video_scan_ctrl

Interface
REQ-001 Parameters: none; all timing constants SHALL come from the shared package.
REQ-002 CLK  in  1  system clock; all state SHALL change on the rising edge only.
REQ-003 CLRn  in  1  reset, asynchronous, active-low.
REQ-004 CE  in  1  scan-advance enable, one CLK-wide pulse per character time (1 MHz).
REQ-005 H  out  7  horizontal count: 0x00, then 0x40..0x7F.
REQ-006 V  out  9  vertical count: V_FIRST..0x1FF.
REQ-007 HPEn  out  1  active-low parallel-load strobe for an external 161 horizontal chain; low while H==0x00.
REQ-008 HBL  out  1  horizontal blank, high while H<0x58.
REQ-009 VBL  out  1  vertical blank, high while V<0x100 or V>=0x1C0.
REQ-010 HSYNC  out  1  high while H in 0x48..0x4B.
REQ-011 VSYNC  out  1  high while V in VSYNC_FIRST..VSYNC_FIRST+3.
REQ-012 LINE_TC  out  1  one-CLK pulse on the CE cycle where H goes 0x7F->0x00.
REQ-013 FRAME_TC  out  1  one-CLK pulse on the CE cycle where V goes 0x1FF->V_FIRST.

Function
REQ-014 H and V SHALL advance only on a CLK edge with CE=1; with CE=0 all registered state SHALL hold.
REQ-015 H sequence SHALL be 0x00 -> 0x40 -> 0x41 ... 0x7F -> 0x00, i.e. 65 CE ticks per line.
REQ-016 V SHALL increment by one exactly when H wraps 0x7F->0x00.
REQ-017 At V==0x1FF with a wrapping H, V SHALL load V_FIRST; no other V value SHALL be reachable.
REQ-018 HPEn, HBL, VBL, HSYNC and VSYNC SHALL be combinational decodes of the current H and V registers, with zero latency.
REQ-019 LINE_TC and FRAME_TC SHALL be registered, asserted in the cycle after the wrapping edge, and cleared on the next CLK regardless of CE.
REQ-020 FRAME_TC SHALL coincide with a LINE_TC pulse; the two SHALL never assert separately at a frame boundary.
REQ-021 CE held high continuously SHALL advance one state per CLK, with no skipped or repeated states.

Reset
REQ-022 While CLRn=0: H=0x00, V=V_FIRST, LINE_TC=0, FRAME_TC=0; decoded outputs follow these values, giving HPEn=0, HBL=1 and VBL=1.
REQ-023 Deassertion of CLRn mid-frame SHALL restart at the top-of-frame state; the first CE after release SHALL give H=0x40.

Configuration
REQ-024 Macro VIDEO_SCAN_PAL_EN undefined: V_FIRST=0x0FA (262 lines), VSYNC_FIRST=0x1E0.
REQ-025 Macro VIDEO_SCAN_PAL_EN defined: V_FIRST=0x0C8 (312 lines), VSYNC_FIRST=0x1F0.
REQ-026 Only these two constants SHALL differ between builds; the port list SHALL be identical in both.

Structure
REQ-027 Package video_scan_pkg SHALL hold H_LOAD=0x40, H_LAST=0x7F, H_VIS=0x58, HSYNC_FIRST=0x48, V_VIS_FIRST=0x100, V_VIS_END=0x1C0, V_FIRST and VSYNC_FIRST (the last two selected by the macro).
REQ-028 One sub-module, scan_cnt_stage, SHALL implement a 4-bit synchronous loadable counter stage with carry-in and carry-out; the H and V counters SHALL be cascades of these stages.

Verification
REQ-029 Release reset, then apply 65 CE pulses -> H sequence 0x00,0x40..0x7F,0x00; exactly one LINE_TC; V=V_FIRST+1.
REQ-030 Run CE continuously for 17030 CE ticks, NTSC build -> exactly one FRAME_TC; H=0x00 and V=0x0FA at the end.
REQ-031 Same run on the PAL build -> FRAME_TC period of 20280 CE ticks; V wraps 0x1FF->0x0C8.
REQ-032 Apply CE in a random 1-of-3 pattern -> state changes only on CE edges; the count sequence matches the continuous-CE run.
REQ-033 Pulse CLRn low for 3 ns at H=0x63, V=0x150, asynchronous to CLK -> H=0x00, V=V_FIRST and HPEn=0 immediately; next CE gives H=0x40.
REQ-034 Sweep a full frame -> HSYNC high for 4 CE ticks per line; VSYNC high for 4 lines; exactly 40x192 ticks with HBL=0 and VBL=0.

Source files
------------

// File: rtl/video_scan_pkg.sv
// Shared timing constants and output decode for the video scan controller.
// Build option: define VIDEO_SCAN_PAL_EN for the 312-line PAL frame (default is 262-line NTSC).
package video_scan_pkg;

   localparam logic [6:0] H_LOAD      = 7'h40;
   localparam logic [6:0] H_LAST      = 7'h7F;
   localparam logic [6:0] H_VIS       = 7'h58;
   localparam logic [6:0] HSYNC_FIRST = 7'h48;
   localparam logic [8:0] V_VIS_FIRST = 9'h100;
   localparam logic [8:0] V_VIS_END   = 9'h1C0;

`ifdef VIDEO_SCAN_PAL_EN
   localparam logic [8:0] V_FIRST     = 9'h0C8;
   localparam logic [8:0] VSYNC_FIRST = 9'h1F0;
`else
   localparam logic [8:0] V_FIRST     = 9'h0FA;
   localparam logic [8:0] VSYNC_FIRST = 9'h1E0;
`endif

   typedef struct packed {
      logic hpen;
      logic hbl;
      logic vbl;
      logic hsync;
      logic vsync;
   } scan_dec_t;

   function automatic scan_dec_t scan_decode(input logic [6:0] h, input logic [8:0] v);
      scan_dec_t d;
      d.hpen  = (h != 7'h00);
      d.hbl   = (h < H_VIS);
      d.vbl   = (v < V_VIS_FIRST) || (v >= V_VIS_END);
      d.hsync = (h >= HSYNC_FIRST) && (h <= HSYNC_FIRST + 7'd3);
      d.vsync = (v >= VSYNC_FIRST) && (v <= VSYNC_FIRST + 9'd3);
      return d;
   endfunction

endpackage

// File: rtl/scan_cnt_stage.sv
// 4-bit synchronous loadable counter slice (74161 style) with carry-in/carry-out for cascading.
module scan_cnt_stage
   import video_scan_pkg::*;
#(
   parameter logic [3:0] RST_VAL = 4'h0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] d,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= RST_VAL;
      else if (load)
         q <= d;
      else if (cin)
         q <= q + 4'd1;
   end

   assign cout = cin & (q == 4'hF);

endmodule

// File: rtl/video_scan_ctrl.sv
// Horizontal/vertical scan counters with blank/sync decode and line/frame terminal-count pulses.
// Build option: VIDEO_SCAN_PAL_EN selects the PAL frame constants in video_scan_pkg.
module video_scan_ctrl
   import video_scan_pkg::*;
(
   input  logic       CLK,
   input  logic       CLRn,
   input  logic       CE,
   output logic [6:0] H,
   output logic [8:0] V,
   output logic       HPEn,
   output logic       HBL,
   output logic       VBL,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       LINE_TC,
   output logic       FRAME_TC
);

   localparam logic [11:0] V_INIT = {3'b000, V_FIRST};

   logic [7:0]  h_cnt;
   logic [2:0]  h_c;
   logic [7:0]  h_d;
   logic        h_zero, h_last, h_load;
   logic [11:0] v_cnt;
   logic [3:0]  v_c;
   logic        v_adv, v_last, v_load;
   scan_dec_t   dec;

   // The final stage carries only fire from an illegal count; they reload a legal value.
   assign h_zero = (h_cnt == 8'h00);
   assign h_last = (h_cnt == {1'b0, H_LAST});
   assign h_load = CE & (h_zero | h_last | h_c[2]);
   assign h_d    = h_zero ? {1'b0, H_LOAD} : 8'h00;
   assign h_c[0] = CE;

   assign v_adv  = CE & h_last;
   assign v_last = (v_cnt == 12'h1FF);
   assign v_load = (v_adv & v_last) | v_c[3];
   assign v_c[0] = v_adv;

   for (genvar i = 0; i < 2; i++) begin : g_h
      scan_cnt_stage #(.RST_VAL(4'h0)) u_stage (
         .clk   (CLK),
         .rst_n (CLRn),
         .load  (h_load),
         .d     (h_d[4*i +: 4]),
         .cin   (h_c[i]),
         .q     (h_cnt[4*i +: 4]),
         .cout  (h_c[i+1])
      );
   end

   for (genvar i = 0; i < 3; i++) begin : g_v
      scan_cnt_stage #(.RST_VAL(V_INIT[4*i +: 4])) u_stage (
         .clk   (CLK),
         .rst_n (CLRn),
         .load  (v_load),
         .d     (V_INIT[4*i +: 4]),
         .cin   (v_c[i]),
         .q     (v_cnt[4*i +: 4]),
         .cout  (v_c[i+1])
      );
   end

   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         LINE_TC  <= 1'b0;
         FRAME_TC <= 1'b0;
      end else begin
         LINE_TC  <= v_adv;
         FRAME_TC <= v_adv & v_last;
      end
   end

   assign H     = h_cnt[6:0];
   assign V     = v_cnt[8:0];
   assign dec   = scan_decode(H, V);
   assign HPEn  = dec.hpen;
   assign HBL   = dec.hbl;
   assign VBL   = dec.vbl;
   assign HSYNC = dec.hsync;
   assign VSYNC = dec.vsync;

endmodule

// File: tb/tb_video_scan_ctrl.sv
// Scoreboard bench for video_scan_ctrl: a reference scan model queues the expected state per clock.
module tb_video_scan_ctrl;

`ifdef VIDEO_SCAN_PAL_EN
   localparam logic [8:0] VF      = 9'h0C8;
   localparam logic [8:0] VSF     = 9'h1F0;
   localparam int         LINES   = 312;
`else
   localparam logic [8:0] VF      = 9'h0FA;
   localparam logic [8:0] VSF     = 9'h1E0;
   localparam int         LINES   = 262;
`endif
   localparam int FRAME_N = LINES * 65;

   logic       CLK = 1'b0;
   logic       CLRn = 1'b0;
   logic       CE = 1'b0;
   logic [6:0] H;
   logic [8:0] V;
   logic       HPEn, HBL, VBL, HSYNC, VSYNC, LINE_TC, FRAME_TC;

   video_scan_ctrl dut (
      .CLK      (CLK),
      .CLRn     (CLRn),
      .CE       (CE),
      .H        (H),
      .V        (V),
      .HPEn     (HPEn),
      .HBL      (HBL),
      .VBL      (VBL),
      .HSYNC    (HSYNC),
      .VSYNC    (VSYNC),
      .LINE_TC  (LINE_TC),
      .FRAME_TC (FRAME_TC)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [6:0] h;
      logic [8:0] v;
      logic       ltc;
      logic       ftc;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int ltc_cnt, ftc_cnt, ftc_at, vis_cnt, hs_cnt, vs_cnt, step_no;

   logic [6:0] m_h;
   logic [8:0] m_v;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_stats();
      ltc_cnt = 0; ftc_cnt = 0; ftc_at = 0; vis_cnt = 0; hs_cnt = 0; vs_cnt = 0; step_no = 0;
   endtask

   task automatic compare_out();
      exp_t e;
      check_val("sb_size", sb.size(), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check_val("h", H, e.h);
      check_val("v", V, e.v);
      check_val("line_tc", LINE_TC, e.ltc);
      check_val("frame_tc", FRAME_TC, e.ftc);
      check_val("hpen", HPEn, e.h != 7'h00);
      check_val("hbl", HBL, e.h < 7'h58);
      check_val("vbl", VBL, (e.v < 9'h100) || (e.v >= 9'h1C0));
      check_val("hsync", HSYNC, (e.h >= 7'h48) && (e.h <= 7'h4B));
      check_val("vsync", VSYNC, (e.v >= VSF) && (e.v <= VSF + 9'd3));
      step_no++;
      if (LINE_TC) ltc_cnt++;
      if (FRAME_TC) begin
         ftc_cnt++;
         ftc_at = step_no;
      end
      if (!HBL && !VBL) vis_cnt++;
      if (HSYNC) hs_cnt++;
      if (VSYNC) vs_cnt++;
   endtask

   // One clock: drive CE, advance the reference model at the edge, check 1 ns later.
   task automatic step(input bit ce);
      exp_t e;
      @(negedge CLK);
      CE = ce;
      @(posedge CLK);
      e.ltc = ce && (m_h == 7'h7F);
      e.ftc = e.ltc && (m_v == 9'h1FF);
      if (ce) begin
         if (m_h == 7'h00) m_h = 7'h40;
         else if (m_h == 7'h7F) begin
            m_h = 7'h00;
            m_v = (m_v == 9'h1FF) ? VF : m_v + 9'd1;
         end else m_h = m_h + 7'd1;
      end
      e.h = m_h;
      e.v = m_v;
      sb.push_back(e);
      #1;
      compare_out();
   endtask

   // Asynchronous 3 ns clear pulse placed between clock edges.
   task automatic pulse_reset(input string tag);
      CE = 1'b0;
      #3 CLRn = 1'b0;
      #1;
      check_val({tag, "_h"}, H, 7'h00);
      check_val({tag, "_v"}, V, VF);
      check_val({tag, "_hpen"}, HPEn, 1'b0);
      check_val({tag, "_hbl"}, HBL, 1'b1);
      check_val({tag, "_vbl"}, VBL, 1'b1);
      check_val({tag, "_ltc"}, LINE_TC, 1'b0);
      check_val({tag, "_ftc"}, FRAME_TC, 1'b0);
      #2 CLRn = 1'b1;
      m_h = 7'h00;
      m_v = VF;
   endtask

   initial begin
      int guard;
      int ce_ticks;
      m_h = 7'h00;
      m_v = VF;

      // Power-on reset held across several clocks with CE active.
      CE = 1'b1;
      #22;
      check_val("rst_h", H, 7'h00);
      check_val("rst_v", V, VF);
      check_val("rst_hpen", HPEn, 1'b0);
      check_val("rst_hbl", HBL, 1'b1);
      check_val("rst_vbl", VBL, 1'b1);
      check_val("rst_ltc", LINE_TC, 1'b0);
      check_val("rst_ftc", FRAME_TC, 1'b0);
      @(negedge CLK);
      CE = 1'b0;
      CLRn = 1'b1;

      // One full line: 0x00, 0x40..0x7F, 0x00.
      clear_stats();
      for (int i = 0; i < 65; i++) step(1'b1);
      step(1'b0);
      check_val("line_ltc_cnt", ltc_cnt, 1);
      check_val("line_end_h", H, 7'h00);
      check_val("line_end_v", V, VF + 9'd1);

      // Full frame with continuous CE from the top-of-frame state.
      pulse_reset("rst_frame");
      clear_stats();
      for (int i = 0; i < FRAME_N; i++) step(1'b1);
      check_val("frame_ftc_cnt", ftc_cnt, 1);
      check_val("frame_ftc_at", ftc_at, FRAME_N);
      check_val("frame_ltc_cnt", ltc_cnt, LINES);
      check_val("frame_end_h", H, 7'h00);
      check_val("frame_end_v", V, VF);
      check_val("frame_vis_ticks", vis_cnt, 40 * 192);
      check_val("frame_hsync_ticks", hs_cnt, 4 * LINES);
      check_val("frame_vsync_ticks", vs_cnt, 4 * 65);

      // Sparse CE in a random 1-of-3 pattern; idle cycles must hold state and drop the pulses.
      ce_ticks = 0;
      for (int i = 0; i < 900; i++) begin
         bit ce;
         ce = ($urandom_range(0, 2) == 0);
         if (ce) ce_ticks++;
         step(ce);
      end
      check_val("rand_ce_ticks_nonzero", ce_ticks > 0, 1'b1);

      // Mid-frame asynchronous clear at H=0x63, V=0x150.
      guard = 0;
      while (!(m_h == 7'h63 && m_v == 9'h150) && guard < 30000) begin
         step(1'b1);
         guard++;
      end
      check_val("reach_h63_v150", guard < 30000, 1'b1);
      check_val("pre_clr_h", H, 7'h63);
      check_val("pre_clr_v", V, 9'h150);
      pulse_reset("async_clr");
      step(1'b0);
      step(1'b1);
      check_val("post_clr_h", H, 7'h40);
      check_val("post_clr_v", V, VF);
      step(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
